// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding and default geometry for the instruction cache
package icache_pkg;
  localparam int INDEX_WIDTH_DEF = 8;
  typedef enum logic {IDLE = 1'b0, MISS = 1'b1} state_e;
endpackage

// File: rtl/icache.sv
// icache: direct-mapped one-word-per-line instruction cache with a single outstanding miss
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = INDEX_WIDTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  input  logic        mem_enable,
  input  logic [31:0] mem_inst,
  input  logic        jump_flag
);
  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = 30 - INDEX_WIDTH;
  state_e                   state_q, state_d;
  logic [LINES-1:0]         valid_q, valid_d;
  logic                     inst_valid_q, inst_valid_d;
  logic [31:0]              inst_q, inst_d;
  logic                     mem_valid_q, mem_valid_d;
  logic [31:2]              mem_addr_q, mem_addr_d;
  logic [TAG_W-1:0]         tag_q [LINES];
  logic [31:0]              data_q [LINES];
  logic [INDEX_WIDTH-1:0]   pc_idx, fill_idx;
  logic [TAG_W-1:0]         pc_tag, fill_tag;
  logic                     hit, fill_we;
  logic                     unused_pc_lsb;
  assign unused_pc_lsb = ^if_pc[1:0];
  assign pc_idx        = if_pc[INDEX_WIDTH+1:2];
  assign pc_tag        = if_pc[31:INDEX_WIDTH+2];
  assign fill_idx      = mem_addr_q[INDEX_WIDTH+1:2];
  assign fill_tag      = mem_addr_q[31:INDEX_WIDTH+2];
  assign hit           = valid_q[pc_idx] && tag_q[pc_idx] == pc_tag;
  assign fill_we       = !rst && rdy && state_q == MISS && mem_enable;
  assign inst_valid    = inst_valid_q;
  assign inst          = inst_q;
  assign mem_valid     = mem_valid_q;
  assign mem_addr      = {mem_addr_q, 2'b00};
  // next state: a fill lands even under a flush, but only an unflushed fill answers the fetch
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    if (rdy) begin
      inst_valid_d = 1'b0;
      if (fill_we) valid_d[fill_idx] = 1'b1;
      if (jump_flag) begin
        mem_valid_d = 1'b0;
        state_d     = IDLE;
      end else if (state_q == IDLE) begin
        if (if_valid && !inst_valid_q) begin
          if (hit) begin
            inst_valid_d = 1'b1;
            inst_d       = data_q[pc_idx];
          end else begin
            mem_valid_d = 1'b1;
            mem_addr_d  = if_pc[31:2];
            state_d     = MISS;
          end
        end
      end else if (mem_enable) begin
        inst_valid_d = 1'b1;
        inst_d       = mem_inst;
        mem_valid_d  = 1'b0;
        state_d      = IDLE;
      end
    end
  end
  // control and output registers; valid bits clear in one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
    end
  end
  // tag/data arrays are never reset so they can map onto RAM
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_inst;
    end
  end
endmodule

// File: tb/tb_icache.sv
// tb_icache: randomized self-checking bench for icache against a line-level reference model
module tb_icache;
  logic        clk = 1'b0;
  logic        rst, rdy, if_valid, mem_enable, jump_flag;
  logic [31:0] if_pc, mem_inst;
  logic        inst_valid, mem_valid;
  logic [31:0] inst, mem_addr;
  int vectors = 0;
  int miscompares = 0;
  bit          mv [256];
  logic [31:0] mt [256];
  logic [31:0] md [256];
  logic [31:0] memv [logic [31:0]];
  icache dut (
    .clk(clk), .rst(rst), .rdy(rdy), .if_valid(if_valid), .if_pc(if_pc),
    .inst_valid(inst_valid), .inst(inst), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_enable(mem_enable), .mem_inst(mem_inst), .jump_flag(jump_flag)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] memw(input logic [31:0] pc);
    return memv.exists(pc) ? memv[pc] : (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 256);
  endfunction
  task automatic model_fill(input logic [31:0] pc, input logic [31:0] d);
    mv[idx_of(pc)] = 1'b1;
    mt[idx_of(pc)] = pc >> 10;
    md[idx_of(pc)] = d;
  endtask
  task automatic model_clear();
    for (int i = 0; i < 256; i++) mv[i] = 1'b0;
  endtask
  task automatic fetch(input logic [31:0] pc, input int delay);
    bit exp_hit, saw_mem, done, bad_addr;
    logic [31:0] exp_d;
    int cnt, lat;
    exp_hit = mv[idx_of(pc)] && mt[idx_of(pc)] == (pc >> 10);
    exp_d = exp_hit ? md[idx_of(pc)] : memw(pc);
    saw_mem = 0; done = 0; bad_addr = 0; cnt = 0; lat = 0;
    @(negedge clk);
    if_valid = 1'b1;
    if_pc = pc;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge clk);
      mem_enable = 1'b0;
      if (inst_valid) begin
        done = 1;
        lat = c;
        if_valid = 1'b0;
      end else if (mem_valid) begin
        saw_mem = 1;
        if (mem_addr !== pc) bad_addr = 1;
        if (cnt == delay) begin
          mem_enable = 1'b1;
          mem_inst = memw(pc);
        end
        cnt++;
      end
    end
    if_valid = 1'b0;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL fetch_timeout pc=%h: no inst_valid within 60 cycles", pc);
    end else begin
      vectors += 4;
      if (inst !== exp_d) begin
        miscompares++;
        $display("FAIL fetch_data pc=%h: got %h expected %h", pc, inst, exp_d);
      end
      if (saw_mem !== !exp_hit) begin
        miscompares++;
        $display("FAIL fetch_memreq pc=%h: mem_valid seen %0d expected %0d", pc, saw_mem, !exp_hit);
      end
      if (lat != (exp_hit ? 1 : delay + 2)) begin
        miscompares++;
        $display("FAIL fetch_latency pc=%h: got %0d expected %0d", pc, lat, exp_hit ? 1 : delay + 2);
      end
      if (bad_addr) begin
        miscompares++;
        $display("FAIL fetch_mem_addr pc=%h: mem_addr %h not equal to pc", pc, mem_addr);
      end
      @(negedge clk);
      vectors++;
      if (inst_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL fetch_single_pulse pc=%h: inst_valid %b expected 0", pc, inst_valid);
      end
    end
    if (!exp_hit) model_fill(pc, exp_d);
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("reset_mem_valid", {31'b0, mem_valid}, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_inst", inst, 32'h0);
    rst = 1'b0;
    model_clear();
  endtask
  task automatic test_cold_miss();
    memv[32'h10] = 32'h0000_0013;
    fetch(32'h10, 2);
  endtask
  task automatic test_hit();
    fetch(32'h10, 0);
  endtask
  task automatic test_conflict();
    fetch(32'h410, 1);
    fetch(32'h10, 0);
    fetch(32'h10, 0);
  endtask
  task automatic test_abort();
    @(negedge clk);
    if_valid = 1'b1;
    if_pc = 32'h20;
    @(negedge clk);
    chk("abort_mem_valid", {31'b0, mem_valid}, 32'h1);
    jump_flag = 1'b1;
    if_valid = 1'b0;
    @(negedge clk);
    jump_flag = 1'b0;
    chk("abort_mem_valid_drop", {31'b0, mem_valid}, 32'h0);
    chk("abort_no_inst", {31'b0, inst_valid}, 32'h0);
    mem_enable = 1'b1;
    mem_inst = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_enable = 1'b0;
    chk("abort_late_enable", {31'b0, inst_valid}, 32'h0);
    @(negedge clk);
    chk("abort_idle", {31'b0, inst_valid | mem_valid}, 32'h0);
    fetch(32'h20, 1);
  endtask
  task automatic test_jump_with_fill();
    @(negedge clk);
    if_valid = 1'b1;
    if_pc = 32'h24;
    @(negedge clk);
    chk("jfill_mem_valid", {31'b0, mem_valid}, 32'h1);
    jump_flag = 1'b1;
    mem_enable = 1'b1;
    mem_inst = memw(32'h24);
    if_valid = 1'b0;
    @(negedge clk);
    jump_flag = 1'b0;
    mem_enable = 1'b0;
    chk("jfill_no_inst", {31'b0, inst_valid}, 32'h0);
    chk("jfill_mem_valid_drop", {31'b0, mem_valid}, 32'h0);
    model_fill(32'h24, memw(32'h24));
    fetch(32'h24, 0);
  endtask
  task automatic test_stall();
    @(negedge clk);
    if_valid = 1'b1;
    if_pc = 32'h30;
    @(negedge clk);
    chk("stall_mem_valid", {31'b0, mem_valid}, 32'h1);
    rdy = 1'b0;
    mem_enable = 1'b1;
    mem_inst = 32'hFFFF_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold_valid", {31'b0, mem_valid}, 32'h1);
      chk("stall_hold_addr", mem_addr, 32'h30);
      chk("stall_no_inst", {31'b0, inst_valid}, 32'h0);
    end
    rdy = 1'b1;
    mem_enable = 1'b0;
    @(negedge clk);
    chk("stall_still_miss", {31'b0, mem_valid}, 32'h1);
    mem_enable = 1'b1;
    mem_inst = memw(32'h30);
    @(negedge clk);
    mem_enable = 1'b0;
    if_valid = 1'b0;
    chk("stall_fill_valid", {31'b0, inst_valid}, 32'h1);
    chk("stall_fill_data", inst, memw(32'h30));
    @(negedge clk);
    chk("stall_single_pulse", {31'b0, inst_valid}, 32'h0);
    model_fill(32'h30, memw(32'h30));
  endtask
  task automatic test_back_to_back();
    fetch(32'h10, 0);
    @(negedge clk);
    if_valid = 1'b1;
    if_pc = 32'h10;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("b2b_inst_valid", {31'b0, inst_valid}, (k % 2 == 1) ? 32'h1 : 32'h0);
      chk("b2b_no_mem", {31'b0, mem_valid}, 32'h0);
    end
    if_valid = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset_mid_miss();
    @(negedge clk);
    if_valid = 1'b1;
    if_pc = 32'h44;
    @(negedge clk);
    chk("rmiss_mem_valid", {31'b0, mem_valid}, 32'h1);
    rst = 1'b1;
    jump_flag = 1'b1;
    rdy = 1'b0;
    if_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    jump_flag = 1'b0;
    rdy = 1'b1;
    chk("rmiss_mem_valid_clr", {31'b0, mem_valid}, 32'h0);
    chk("rmiss_mem_addr_clr", mem_addr, 32'h0);
    chk("rmiss_inst_clr", inst, 32'h0);
    mem_enable = 1'b1;
    mem_inst = 32'h1234_5678;
    @(negedge clk);
    mem_enable = 1'b0;
    chk("rmiss_late_enable", {31'b0, inst_valid}, 32'h0);
    model_clear();
    fetch(32'h10, 0);
    fetch(32'h44, 1);
  endtask
  task automatic test_random();
    logic [31:0] pc;
    for (int n = 0; n < 150; n++) begin
      pc = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 2);
      if ($urandom_range(0, 9) == 0) memv[pc] = $urandom;
      fetch(pc, $urandom_range(0, 3));
    end
  endtask
  initial begin
    rst = 1'b1; rdy = 1'b1; if_valid = 1'b0; if_pc = '0;
    mem_enable = 1'b0; mem_inst = '0; jump_flag = 1'b0;
    model_clear();
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_abort();
    test_jump_with_fill();
    test_stall();
    test_back_to_back();
    test_reset_mid_miss();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter INDEX_WIDTH, default 8, log2 of the line count; one 32-bit word per line, direct-mapped.
REQ-002 Clocking: single clock; reset synchronous, active-high.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 rdy  input  1  global ready; low freezes the block.
REQ-006 if_valid  input  1  fetch request, held with if_pc stable until inst_valid.
REQ-007 if_pc  input  32  fetch address, word-aligned.
REQ-008 inst_valid  output  1  one-cycle response strobe.
REQ-009 inst  output  32  instruction for the accepted if_pc, valid with inst_valid.
REQ-010 mem_valid  output  1  miss request to the memory controller, held until mem_enable or abort.
REQ-011 mem_addr  output  32  miss address {pc[31:2],2'b00}, stable while mem_valid.
REQ-012 mem_enable  input  1  one-cycle fill-complete strobe from the memory controller.
REQ-013 mem_inst  input  32  fill word, little-endian assembled, valid with mem_enable.
REQ-014 jump_flag  input  1  pipeline flush; aborts any outstanding fetch.

Function
REQ-015 Index = if_pc[INDEX_WIDTH+1:2]; tag = if_pc[31:INDEX_WIDTH+2]; per-line valid bit, tag, data.
REQ-016 States IDLE, MISS; encodings in config.v.
REQ-017 IDLE accepts a request when if_valid high, inst_valid low, jump_flag low.
REQ-018 Hit (valid and tag match) on accept at edge N: inst_valid high with line data during cycle N+1, state stays IDLE.
REQ-019 Miss on accept at edge N: mem_valid high and mem_addr set from cycle N+1; state -> MISS; fill-tag captured.
REQ-020 MISS, mem_enable high: write line (data, tag, valid=1); inst <= mem_inst; inst_valid pulse next cycle; mem_valid low next cycle; -> IDLE.
REQ-021 mem_enable sampled while IDLE is ignored: no write, no inst_valid.
REQ-022 inst_valid is never high two consecutive cycles; deasserted by default each cycle.
REQ-023 jump_flag high (rdy high) in any state: mem_valid low, inst_valid low next cycle, -> IDLE; no request accepted that cycle.
REQ-024 jump_flag and mem_enable same cycle in MISS: line still written (address matches captured tag); inst_valid not asserted.
REQ-025 rdy low: no state, array or output change; mem_valid/mem_addr held so the controller restarts the fetch after rdy returns; mem_enable ignored.
REQ-026 Same-line refill overwrites unconditionally; no replacement policy beyond direct map.

Reset
REQ-027 rst high: state IDLE, all valid bits 0, inst_valid 0, mem_valid 0, mem_addr 0, inst 0; data/tag arrays not cleared.
REQ-028 rst mid-MISS: request dropped, a late mem_enable is ignored per REQ-021.
REQ-029 rst takes priority over rdy and jump_flag.

Structure
REQ-030 HIGH/LOW and state encodings live in shared config.v; INDEX_WIDTH default also defined there.
REQ-031 Single module, no sub-modules; arrays as inferred register/RAM vectors, valid bits as a flat vector for single-cycle reset.

Verification
REQ-032 Cold miss: reset, if_pc=0x0000_0010 held -> mem_valid, mem_addr=0x10; mem_enable with mem_inst=0x0000_0013 -> next cycle inst_valid, inst=0x0000_0013, mem_valid low.
REQ-033 Hit: re-request 0x10 after fill -> inst_valid exactly one cycle after accept, inst=0x13, mem_valid never asserted.
REQ-034 Conflict: fill 0x10, then request 0x410 (same index, INDEX_WIDTH=8) -> miss, refill; then 0x10 -> miss again.
REQ-035 Abort: miss on 0x20, jump_flag pulse before mem_enable, mem_enable arrives the cycle after -> no inst_valid; later request 0x20 still a miss or hit only per REQ-024.
REQ-036 rdy stall: miss on 0x30, drop rdy 5 cycles mid-fill -> mem_valid/mem_addr=0x30 held; after rdy returns fill completes, inst_valid once.
REQ-037 Back-to-back: if_valid held through inst_valid cycle -> no duplicate response; new request accepted only the following cycle.
